// File: rtl/q88_sat_accum_if.sv
// Handshake bundle between the capped Q8.8 multiplier, the dot-product
// accumulator and the update stage. The master drives products and the consumer ready.
interface q88_sat_accum_if #(
  parameter int DIM = 4
) ();
  localparam int IDX_W = $clog2(DIM);

  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic              in_ovf;
  logic              in_unf;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic              out_sat;
  logic [IDX_W-1:0]  elem_idx;

  modport master (
    output clear, in_valid, in_data, in_ovf, in_unf, out_ready,
    input  in_ready, out_valid, out_data, out_sat, elem_idx
  );

  modport slave (
    input  clear, in_valid, in_data, in_ovf, in_unf, out_ready,
    output in_ready, out_valid, out_data, out_sat, elem_idx
  );
endinterface

// File: rtl/q88_sat_accum.sv
// Saturating Q8.8 dot-product accumulator: sums DIM products into one clamped result.
// Q88_ACC_GUARD_EN selects a wide exact accumulator with a single final clamp.
module q88_sat_accum #(
  parameter int DIM = 4
) (
  input  logic            clk,
  input  logic            rst,
  q88_sat_accum_if.slave  bus
);
  localparam int IDX_W = $clog2(DIM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

`ifdef Q88_ACC_GUARD_EN
  localparam int ACC_W = 16 + IDX_W + 1;
  localparam int SUM_W = ACC_W;
`else
  localparam int ACC_W = 16;
  localparam int SUM_W = 17;
`endif

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // The value fits Q8.8 only when every bit from 15 upward equals the sign.
  function automatic logic sat_hit(input logic signed [SUM_W-1:0] v);
    return !((&v[SUM_W-1:15]) || !(|v[SUM_W-1:15]));
  endfunction

  function automatic logic [15:0] sat_q88(input logic signed [SUM_W-1:0] v);
    logic [15:0] r;
    if (sat_hit(v)) begin
      r = v[SUM_W-1] ? 16'h8000 : 16'h7FFF;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      sticky_q, sticky_d;
  logic [IDX_W-1:0]          elem_idx_q, elem_idx_d;
  logic                      out_valid_q, out_valid_d;
  logic [15:0]               out_data_q, out_data_d;
  logic                      out_sat_q, out_sat_d;

  logic                      in_ready_s;
  logic                      in_hs_s;
  logic signed [SUM_W-1:0]   sum_s;
  logic signed [ACC_W-1:0]   acc_next_s;
  logic                      add_hit_s;
  logic                      flag_s;

  assign in_ready_s = (state_q == ST_ACC) && !rst;
  assign in_hs_s    = bus.in_valid && in_ready_s;
  assign sum_s      = SUM_W'(acc_q) + SUM_W'($signed(bus.in_data));

`ifdef Q88_ACC_GUARD_EN
  assign acc_next_s = sum_s;
  assign add_hit_s  = 1'b0;
`else
  // Narrow mode clamps on every add, so the running value never leaves Q8.8.
  assign acc_next_s = $signed(sat_q88(sum_s));
  assign add_hit_s  = sat_hit(sum_s);
`endif

  assign flag_s = sticky_q | bus.in_ovf | bus.in_unf | add_hit_s;

  // Next-state logic: clear overrides any handshake in the same cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    elem_idx_d  = elem_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (bus.clear) begin
      state_d     = ST_ACC;
      acc_d       = {ACC_W{1'b0}};
      sticky_d    = 1'b0;
      elem_idx_d  = {IDX_W{1'b0}};
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_hs_s) begin
            acc_d    = acc_next_s;
            sticky_d = flag_s;
            if (elem_idx_q == LAST_IDX) begin
              out_data_d  = sat_q88(sum_s);
              out_sat_d   = flag_s | sat_hit(sum_s);
              out_valid_d = 1'b1;
              elem_idx_d  = {IDX_W{1'b0}};
              state_d     = ST_HOLD;
            end else begin
              elem_idx_d = elem_idx_q + IDX_W'(1);
            end
          end else begin
            state_d = ST_ACC;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            acc_d       = {ACC_W{1'b0}};
            sticky_d    = 1'b0;
            state_d     = ST_ACC;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_ACC;
        end
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= {ACC_W{1'b0}};
      sticky_q    <= 1'b0;
      elem_idx_q  <= {IDX_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      elem_idx_q  <= elem_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.elem_idx  = elem_idx_q;
endmodule

// File: tb/tb_q88_sat_accum.sv
// Self-checking bench for q88_sat_accum (DIM=4): vector table, backpressure,
// abort and reset corners, then random vectors against an arithmetic model.
module tb_q88_sat_accum;
  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  q88_sat_accum_if #(.DIM(4)) bus ();
  q88_sat_accum #(.DIM(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0][15:0] d;
    logic [3:0]       ovf;
    logic [3:0]       unf;
    logic [15:0]      exp_data;
    logic             exp_sat;
  } vec_t;

  vec_t tbl [6];

  function automatic vec_t mk(input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3,
                              input logic [3:0] ovf, input logic [3:0] unf,
                              input logic [15:0] ed, input logic es);
    vec_t v;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.ovf = ovf; v.unf = unf; v.exp_data = ed; v.exp_sat = es;
    return v;
  endfunction

  // Reference: integer sum of the products, clamped to Q8.8 as the build dictates.
  function automatic void ref_model(input logic [3:0][15:0] d, input logic [3:0] fl,
                                    output logic [15:0] r, output logic s);
    int acc;
    acc = 0;
    s = |fl;
`ifdef Q88_ACC_GUARD_EN
    for (int k = 0; k < 4; k++) acc += int'($signed(d[k]));
    if (acc > 32767) begin acc = 32767; s = 1'b1; end
    else if (acc < -32768) begin acc = -32768; s = 1'b1; end
`else
    for (int k = 0; k < 4; k++) begin
      acc += int'($signed(d[k]));
      if (acc > 32767) begin acc = 32767; s = 1'b1; end
      else if (acc < -32768) begin acc = -32768; s = 1'b1; end
    end
`endif
    r = 16'(acc);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic push(input logic [15:0] d, input logic ovf, input logic unf);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_ovf = ovf; bus.in_unf = unf;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("push_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.in_ovf = 1'b0; bus.in_unf = 1'b0;
  endtask

  // Waits for a result, checks it, then completes the output handshake.
  task automatic collect(input string nm, input logic [15:0] ed, input logic es, input bit rnd);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({nm, "_data"}, 32'(bus.out_data), 32'(ed));
    check({nm, "_sat"}, 32'(bus.out_sat), 32'(es));
    n = 0;
    while (n < 50) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({nm, "_drain_timeout"}, 32'(bus.out_ready), 32'd1);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    logic [3:0][15:0] rd;
    logic [3:0]       rf;
    logic [15:0]      er;
    logic             es;

    tbl[0] = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400, 4'b0000, 4'b0000, 16'h0A00, 1'b0);
`ifdef Q88_ACC_GUARD_EN
    tbl[1] = mk(16'h7000, 16'h7000, 16'h9000, 16'h0000, 4'b0000, 4'b0000, 16'h7000, 1'b0);
`else
    tbl[1] = mk(16'h7000, 16'h7000, 16'h9000, 16'h0000, 4'b0000, 4'b0000, 16'h0FFF, 1'b1);
`endif
    tbl[2] = mk(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 4'b0000, 16'h7FFF, 1'b1);
    tbl[3] = mk(16'h0001, 16'h0002, 16'h0003, 16'h0004, 4'b0000, 4'b0000, 16'h000A, 1'b0);
    tbl[4] = mk(16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h8000, 1'b1);
    tbl[5] = mk(16'h1234, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 4'b0100, 16'h1234, 1'b1);

    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = 16'h0000;
    bus.in_ovf = 1'b0; bus.in_unf = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_out_sat", 32'(bus.out_sat), 32'd0);
    check("rst_elem_idx", 32'(bus.elem_idx), 32'd0);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Table vectors with out_ready held high: single-cycle out_valid pulse.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 4; k++) begin
        push(tbl[v].d[k], tbl[v].ovf[k], tbl[v].unf[k]);
        if (k == 2) begin
          check($sformatf("tbl%0d_idx", v), 32'(bus.elem_idx), 32'd3);
          check($sformatf("tbl%0d_early_valid", v), 32'(bus.out_valid), 32'd0);
        end
      end
      collect($sformatf("tbl%0d", v), tbl[v].exp_data, tbl[v].exp_sat, 1'b0);
      @(negedge clk);
      check($sformatf("tbl%0d_pulse", v), 32'(bus.out_valid), 32'd0);
    end

    // Backpressure: result held and offered inputs ignored while stalled.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(tbl[0].d[k], 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_data", 32'(bus.out_data), 32'h0A00);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b1; bus.in_data = 16'h7FFF;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 4; k++) push(16'h0100, 1'b0, 1'b0);
    collect("bp_next", 16'h0400, 1'b0, 1'b0);

    // Abort mid-vector; the input offered alongside clear must be dropped.
    push(16'h0300, 1'b0, 1'b0);
    push(16'h0300, 1'b1, 1'b0);
    @(negedge clk);
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'h0100;
    @(posedge clk);
    #1;
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("clr_elem_idx", 32'(bus.elem_idx), 32'd0);
    check("clr_out_valid", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 4; k++) push(16'h0100, 1'b0, 1'b0);
    collect("clr_next", 16'h0400, 1'b0, 1'b0);

    // Reset while holding a result.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(16'h0200, 1'b0, 1'b0);
    @(negedge clk);
    check("hold_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("hold_rst_valid", 32'(bus.out_valid), 32'd0);
    check("hold_rst_data", 32'(bus.out_data), 32'h0);
    check("hold_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("hold_rst_release", 32'(bus.in_ready), 32'd1);

    // Random vectors with input gaps and output stalls.
    for (int v = 0; v < 100; v++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 1) rd[k] = 16'($urandom);
        else rd[k] = 16'($urandom_range(0, 2047) - 1024);
        rf[k] = ($urandom_range(0, 7) == 0);
      end
      ref_model(rd, rf, er, es);
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (rf[k]) push(rd[k], $urandom_range(0, 1) == 1, 1'b1);
        else push(rd[k], 1'b0, 1'b0);
      end
      collect($sformatf("rnd%0d", v), er, es, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/q88_sat_accum.md
# q88_sat_accum

Saturating dot-product accumulator for the 4D gradient-descent datapath. It sits directly downstream of the capped Q8.8 multiplier. It consumes one Q8.8 product per handshake, together with the multiplier's overflow and underflow flags, and sums DIM products into one saturated Q8.8 result. It presents that result to the update stage over a valid/ready handshake, with a per-vector sticky saturation flag.

## Interface
- DIM, 4: products per vector (dimension count); legal range ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort: drop the partial vector and any held result.
- in_valid  in  1  product valid.
- in_ready  out  1  block accepts a product this cycle.
- in_data  in  16  signed Q8.8 product from the multiplier.
- in_ovf  in  1  multiplier positive-cap flag for in_data.
- in_unf  in  1  multiplier negative-cap flag for in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  16  signed Q8.8 saturated dot product.
- out_sat  out  1  saturation occurred somewhere in this vector.
- elem_idx  out  $clog2(DIM)  index of the next product to be accepted.

## Operation
- Two states: ACC and HOLD. Reset state is ACC.
- In ACC:
  - in_ready=1.
  - An input handshake (in_valid & in_ready) adds in_data to the accumulator.
  - The handshake ORs in_ovf|in_unf into the sticky flag and increments elem_idx.
- On the handshake with elem_idx==DIM-1:
  - The saturated sum is registered into out_data.
  - The sticky flag, including any saturation event on this final add, is registered into out_sat.
  - out_valid goes to 1, elem_idx wraps to 0 and the state moves to HOLD.
- In HOLD:
  - in_ready=0, and out_data/out_sat are held stable while out_valid=1.
  - On out_ready=1: out_valid drops, the accumulator and sticky flag clear, and the state returns to ACC.
- Saturation clamps to the range 0x8000 (-128.0) to 0x7FFF (127.99609375). A clamp event sets the sticky flag.
- clear has priority over every handshake in its cycle:
  - The next state is ACC, with accumulator=0, sticky=0, elem_idx=0 and out_valid=0.
  - An input or output handshake coinciding with clear is discarded.
- in_valid is ignored while in_ready=0. in_data/in_ovf/in_unf are sampled only on a handshake.
- rst asserted at any time immediately forces the reset values below, including mid-vector and during HOLD.

## Timing
- Reset values:
  - out_valid=0, out_data=0x0000, out_sat=0, elem_idx=0, state=ACC.
  - in_ready is 0 while rst=1 and 1 from the first cycle after deassertion.
- in_ready is combinational from the state and rst only. It never depends on in_valid.
- Latency: out_valid rises on the clock edge of the DIM-th input handshake and is visible in the following cycle.
- Throughput: at best one vector per DIM+1 cycles, when out_ready is held at 1. A stalled out_ready holds HOLD indefinitely.
- out_valid never drops without an out_ready handshake, except on clear or rst.

## Configuration
- Q88_ACC_GUARD_EN defined:
  - The accumulator is 16+$clog2(DIM)+1 bits signed.
  - Products add exactly. Saturation to Q8.8 is applied once, when the result is registered.
  - out_sat = any in_ovf/in_unf, or the final clamp.
- Q88_ACC_GUARD_EN undefined:
  - The accumulator is 16 bits.
  - Every add saturates to the Q8.8 range, so intermediate clamps are order-dependent.
  - out_sat = any input flag, or any per-add clamp.

## Test plan
- Reset then DIM=4: inputs 0x0100, 0x0200, 0x0300, 0x0400 with no flags, out_ready=1 -> out_data=0x0A00, out_sat=0. out_valid is high for exactly 1 cycle, the cycle after the 4th handshake.
- Inputs 0x7000, 0x7000, 0x9000, 0x0000:
  - With Q88_ACC_GUARD_EN -> out_data=0x7000, out_sat=0.
  - Without it -> out_data=0x0FFF, out_sat=1.
- Inputs 0x7FFF with in_ovf=1, then 0x0000 ×3 -> out_data=0x7FFF, out_sat=1. The next vector, with no flags, -> out_sat=0 (sticky flag cleared per vector).
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, offered inputs ignored.
  - Raise out_ready -> state returns to ACC and the next vector sums correctly.
- Abort: clear asserted after 2 handshakes -> elem_idx=0, then 4 new inputs of 0x0100 -> out_data=0x0400. Assert rst during HOLD -> out_valid=0 immediately.
- Random in_valid gaps over 100 vectors, checked against a reference model -> every result and out_sat match, with no dropped or duplicated products.
